// File: rtl/mod3_pkg.sv
// Shared types and constants for the S3 trit packer: trit type, base-3 place weights.
package mod3_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_ILLEGAL   = 2'b11;
  localparam int    TRITS_PER_BYTE = 5;

  localparam logic [7:0] POW3 [TRITS_PER_BYTE] = '{8'd1, 8'd3, 8'd9, 8'd27, 8'd81};

  // Slot indices beyond the last place weight yield 0 so a stray index cannot corrupt a byte.
  function automatic logic [7:0] pow3_of(input logic [2:0] k);
    case (k)
      3'd0:    return POW3[0];
      3'd1:    return POW3[1];
      3'd2:    return POW3[2];
      3'd3:    return POW3[3];
      3'd4:    return POW3[4];
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/mod3_pack_mac.sv
// Combinational base-3 multiply-accumulate: o_sum = i_acc + t * 3^k.
module mod3_pack_mac
  import mod3_pkg::*;
(
  input  logic [7:0] i_acc,
  input  trit_t      i_trit,
  input  logic [2:0] i_k,
  output logic [7:0] o_sum
);

  logic [7:0] w_w;

  // t*w is w or 2w; the illegal trit contributes nothing.
  always_comb begin
    w_w   = pow3_of(i_k);
    o_sum = i_acc;
    case (i_trit)
      2'd1:    o_sum = i_acc + w_w;
      2'd2:    o_sum = i_acc + {w_w[6:0], 1'b0};
      default: o_sum = i_acc;
    endcase
  end

endmodule

// File: rtl/mod3_pack_s3.sv
// Streaming S3 trit packer: five trits per byte, little-endian base 3, framed per N_COEF.
// Optional illegal-trit flag 'err' is built only when MOD3_PACK_CHECK_EN is defined.
module mod3_pack_s3
  import mod3_pkg::*;
#(
  parameter int N_COEF = 700
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  input  trit_t      in_trit,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_last,
  input  logic       out_ready
`ifdef MOD3_PACK_CHECK_EN
  ,
  output logic       err
`endif
);

  localparam int CW = $clog2(N_COEF + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(N_COEF - 1);
  localparam logic [2:0]    LAST_SLOT = 3'(TRITS_PER_BYTE - 1);

  logic [7:0]    r_acc;
  logic [2:0]    r_k;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_out_byte;
  logic          r_out_last;
  logic          r_out_valid;

  logic          w_accept;
  logic          w_last;
  logic          w_flush;
  logic [7:0]    w_sum;

  // Handshakes: a trit moves when in_valid && in_ready, a byte when out_valid && out_ready.
  // A trit offered together with clr is not taken into the packer.
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready && !clr;
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_flush   = w_accept && ((r_k == LAST_SLOT) || w_last);

  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign out_last  = r_out_last;

  mod3_pack_mac u_mac (
    .i_acc  (r_acc),
    .i_trit (in_trit),
    .i_k    (r_k),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= 8'd0;
      r_k         <= 3'd0;
      r_cnt       <= '0;
      r_out_byte  <= 8'd0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // A load in the same cycle as a consume keeps the output register full.
      if (w_flush) begin
        r_out_valid <= 1'b1;
        r_out_byte  <= w_sum;
        r_out_last  <= w_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (clr) begin
        r_acc <= 8'd0;
        r_k   <= 3'd0;
        r_cnt <= '0;
      end else if (w_accept) begin
        if (w_flush) begin
          r_acc <= 8'd0;
          r_k   <= 3'd0;
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end else begin
          r_acc <= w_sum;
          r_k   <= r_k + 3'd1;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

`ifdef MOD3_PACK_CHECK_EN
  logic r_err;

  assign err = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (clr) begin
      r_err <= 1'b0;
    end else if (w_accept && (in_trit == TRIT_ILLEGAL)) begin
      r_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mod3_pack_s3.sv
// Bench for mod3_pack_s3: table vectors, corner sequences and a queue-based reference model.
module tb_mod3_pack_s3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_trit = 2'd0;
  logic       out_ready = 1'b1;
  logic       sel = 1'b0;
  logic       bp = 1'b0;

  always #5 clk = ~clk;

  logic       iv_a, iv_b;
  logic       in_ready_a, out_valid_a, out_last_a;
  logic       in_ready_b, out_valid_b, out_last_b;
  logic [7:0] out_byte_a, out_byte_b;
  logic       in_ready, out_valid, out_last;
  logic [7:0] out_byte;
`ifdef MOD3_PACK_CHECK_EN
  logic       err_a, err_b;
`endif

  assign iv_a      = in_valid && !sel;
  assign iv_b      = in_valid && sel;
  assign in_ready  = sel ? in_ready_b  : in_ready_a;
  assign out_valid = sel ? out_valid_b : out_valid_a;
  assign out_last  = sel ? out_last_b  : out_last_a;
  assign out_byte  = sel ? out_byte_b  : out_byte_a;

  mod3_pack_s3 #(.N_COEF(700)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv_a), .in_trit(in_trit),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_byte(out_byte_a),
    .out_last(out_last_a), .out_ready(out_ready)
`ifdef MOD3_PACK_CHECK_EN
    , .err(err_a)
`endif
  );

  mod3_pack_s3 #(.N_COEF(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv_b), .in_trit(in_trit),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_byte(out_byte_b),
    .out_last(out_last_b), .out_ready(out_ready)
`ifdef MOD3_PACK_CHECK_EN
    , .err(err_b)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a byte is the base-3 number formed by up to five trits, first trit least significant.
  function automatic logic [7:0] pack_trits(input int tr[$]);
    int s = 0;
    int w = 1;
    foreach (tr[i]) begin
      if (tr[i] != 3) s += tr[i] * w;
      w *= 3;
    end
    return s[7:0];
  endfunction

  logic [8:0] exp_q_a[$];
  logic [8:0] exp_q_b[$];
  int cur_a[$];
  int cur_b[$];
  int cnt_a = 0, cnt_b = 0;
  int nbytes_a = 0, nlast_a = 0, last_idx_a = 0;

  always @(negedge clk) begin : model_a
    logic [8:0] e;
    if (!rst_n) begin
      exp_q_a.delete(); cur_a.delete(); cnt_a = 0;
      nbytes_a = 0; nlast_a = 0; last_idx_a = 0;
    end else begin
      if (out_valid_a && out_ready) begin
        if (exp_q_a.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL a_unexpected: got byte 0x%0h with no byte expected", out_byte_a);
        end else begin
          e = exp_q_a.pop_front();
          check("a_stream", 32'({out_last_a, out_byte_a}), 32'(e));
          nbytes_a++;
          if (out_last_a) begin nlast_a++; last_idx_a = nbytes_a; end
        end
      end
      if (clr) begin
        cur_a.delete(); cnt_a = 0;
      end else if (iv_a && in_ready_a) begin
        cur_a.push_back(int'(in_trit));
        cnt_a++;
        if (cur_a.size() == 5 || cnt_a == 700) begin
          exp_q_a.push_back({cnt_a == 700, pack_trits(cur_a)});
          cur_a.delete();
          if (cnt_a == 700) cnt_a = 0;
        end
      end
    end
  end

  always @(negedge clk) begin : model_b
    logic [8:0] e;
    if (!rst_n) begin
      exp_q_b.delete(); cur_b.delete(); cnt_b = 0;
    end else begin
      if (out_valid_b && out_ready) begin
        if (exp_q_b.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL b_unexpected: got byte 0x%0h with no byte expected", out_byte_b);
        end else begin
          e = exp_q_b.pop_front();
          check("b_stream", 32'({out_last_b, out_byte_b}), 32'(e));
        end
      end
      if (clr) begin
        cur_b.delete(); cnt_b = 0;
      end else if (iv_b && in_ready_b) begin
        cur_b.push_back(int'(in_trit));
        cnt_b++;
        if (cur_b.size() == 5 || cnt_b == 7) begin
          exp_q_b.push_back({cnt_b == 7, pack_trits(cur_b)});
          cur_b.delete();
          if (cnt_b == 7) cnt_b = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left at 1 time unit after a rising edge; in_valid stays high on return.
  task automatic put(input logic [1:0] t);
    bit ok = 0;
    in_valid = 1'b1;
    in_trit  = t;
    for (int c = 0; c < 64; c++) begin
      if (bp) out_ready = ($urandom_range(0, 3) != 0) || (c > 4);
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL put_timeout: in_ready stayed 0, expected 1 within 64 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_out(input string name, input logic [7:0] b, input logic l);
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_byte"},  32'(out_byte),  32'(b));
    check({name, "_last"},  32'(out_last),  32'(l));
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_in_ready",  32'(in_ready_a),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] t [5];
    logic [7:0] b;
  } vec_t;

  vec_t tab [8];

  // ---------------- test sequence ----------------
  initial begin : main
    longint t0, t1;

    tab[0].t = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2}; tab[0].b = 8'hC4;
    tab[1].t = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1}; tab[1].b = 8'h51;
    tab[2].t = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2}; tab[2].b = 8'hF2;
    tab[3].t = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1}; tab[3].b = 8'h79;
    tab[4].t = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0}; tab[4].b = 8'h00;
    tab[5].t = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0}; tab[5].b = 8'h02;
    tab[6].t = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0}; tab[6].b = 8'h39;
    tab[7].t = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd1}; tab[7].b = 8'h78;

    // reset values
    repeat (2) @(negedge clk);
    check("reset_in_ready",  32'(in_ready_a),  32'd1);
    check("reset_out_valid", 32'(out_valid_a), 32'd0);
    check("reset_out_byte",  32'(out_byte_a),  32'd0);
    check("reset_out_last",  32'(out_last_a),  32'd0);
`ifdef MOD3_PACK_CHECK_EN
    check("reset_err", 32'(err_a), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // table vectors: byte appears the cycle after the fifth trit
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 5; j++) put(tab[i].t[j]);
      expect_out("tab", tab[i].b, 1'b0);
    end

    // reset mid-byte discards the partial byte
    put(2'd1); put(2'd2); put(2'd1);
    idle(1);
    pulse_reset();
    idle(1);
    put(2'd0); put(2'd0); put(2'd0); put(2'd0); put(2'd1);
    expect_out("after_reset", 8'h51, 1'b0);

    // backpressure: stall with a trit offered, then release
    put(2'd2); put(2'd1); put(2'd0); put(2'd0); put(2'd1);
    out_ready = 1'b0;
    in_trit   = 2'd1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready_a),  32'd0);
      check("bp_out_valid", 32'(out_valid_a), 32'd1);
      check("bp_out_byte",  32'(out_byte_a),  32'h56);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_consumed", 32'(out_valid_a), 32'd0);
    @(posedge clk); #1;
    put(2'd0); put(2'd0); put(2'd0); put(2'd2);
    expect_out("bp_next", 8'hA3, 1'b0);

    // short polynomial on the N_COEF=7 instance
    sel = 1'b1;
    repeat (5) put(2'd2);
    expect_out("n7_first", 8'hF2, 1'b0);
    put(2'd1); put(2'd1);
    expect_out("n7_last", 8'h04, 1'b1);
    put(2'd1); put(2'd0); put(2'd0); put(2'd0); put(2'd0);
    expect_out("n7_fresh", 8'h01, 1'b0);
    sel = 1'b0;
    idle(1);

    // clr drops the partial byte and the trit offered with it
    put(2'd2); put(2'd2);
    clr = 1'b1; in_valid = 1'b1; in_trit = 2'd2;
    @(negedge clk);
    check("clr_in_ready", 32'(in_ready_a), 32'd1);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    put(2'd0); put(2'd0); put(2'd0); put(2'd0); put(2'd1);
    expect_out("after_clr", 8'h51, 1'b0);

`ifdef MOD3_PACK_CHECK_EN
    put(2'd3); put(2'd1); put(2'd1); put(2'd1); put(2'd1);
    expect_out("illegal", 8'h78, 1'b0);
    check("err_set", 32'(err_a), 32'd1);
    idle(3);
    check("err_sticky", 32'(err_a), 32'd1);
    clr = 1'b1; in_valid = 1'b1; in_trit = 2'd1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("err_cleared", 32'(err_a), 32'd0);
    @(posedge clk); #1;
`endif

    // full polynomial of random trits, back to back
    pulse_reset();
    idle(1);
    t0 = $time;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 15) == 0) put(2'd3);
      else put(2'($urandom_range(0, 2)));
    end
    t1 = $time;
    idle(3);
    check("no_bubbles_cycles", 32'((t1 - t0) / 10), 32'd700);
    check("poly_bytes",        32'(nbytes_a),   32'd140);
    check("poly_last_count",   32'(nlast_a),    32'd1);
    check("poly_last_index",   32'(last_idx_a), 32'd140);

    // random backpressure
    bp = 1'b1;
    for (int i = 0; i < 300; i++) put(2'($urandom_range(0, 2)));
    bp = 1'b0;
    out_ready = 1'b1;
    idle(5);

    check("a_queue_empty", 32'(exp_q_a.size()), 32'd0);
    check("b_queue_empty", 32'(exp_q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
